// File: rtl/ltc2668_cmd_sequencer.sv
// LTC2668 command FIFO and 3-byte frame serialiser feeding the SPIMasterCS byte handshake.
// Define LTC2668_READBACK_EN to include the SDO echo capture (o_rdbk / o_rdbk_valid).
module ltc2668_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned FRAME_BYTES = 3
) (
  input  logic        i_FPGA_clk,
  input  logic        i_FPGA_rst,
  input  logic [3:0]  i_cmd,
  input  logic [3:0]  i_addr,
  input  logic [15:0] i_data,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  output logic [4:0]  o_MOSI_count,
  output logic [7:0]  o_MOSI,
  output logic        o_MOSIdv,
  input  logic        i_MOSI_ready,
  input  logic [7:0]  i_MISO,
  input  logic        i_MISOdv,
  output logic [23:0] o_rdbk,
  output logic        o_rdbk_valid,
  output logic        o_frame_done,
  output logic        o_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = $clog2(FRAME_BYTES);
  localparam int unsigned RW = $clog2(FRAME_BYTES + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PULSE, S_WAIT} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, count_c;
  logic [23:0]    mem_q [FIFO_DEPTH];
  logic [23:0]    frame_q, frame_d;
  logic [BW-1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]     mosi_q, mosi_d;
  logic           mosidv_q, mosidv_d;
  logic           frame_done_q, frame_done_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           busy_q, busy_d;
  logic           full_c, push_c, frame_start_c, frame_end_c;

  assign count_c = wptr_q - rptr_q;
  assign full_c  = (count_c == PW'(FIFO_DEPTH));
  assign push_c  = i_cmd_valid & ~full_c;

  // FIFO storage; pointers live in the main register block
  always_ff @(posedge i_FPGA_clk) begin
    if (push_c) mem_q[wptr_q[AW-1:0]] <= {i_cmd, i_addr, i_data};
  end

  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q + PW'(push_c);
    rptr_d        = rptr_q;
    frame_d       = frame_q;
    byte_idx_d    = byte_idx_q;
    mosi_d        = mosi_q;
    mosidv_d      = 1'b0;
    frame_done_d  = 1'b0;
    frame_start_c = 1'b0;
    frame_end_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_c != '0) begin
          frame_d       = mem_q[rptr_q[AW-1:0]];
          rptr_d        = rptr_q + PW'(1);
          byte_idx_d    = '0;
          frame_start_c = 1'b1;
          state_d       = S_SEND;
        end
      end
      S_SEND: begin
        if (i_MOSI_ready) begin
          mosi_d   = frame_q[23:16];
          mosidv_d = 1'b1;
          state_d  = S_PULSE;
        end
      end
      S_PULSE: begin
        // frame register shifts so the next byte is always at the top
        if (byte_idx_q == BW'(FRAME_BYTES - 1)) begin
          state_d = S_WAIT;
        end else begin
          byte_idx_d = byte_idx_q + BW'(1);
          frame_d    = {frame_q[15:0], 8'h00};
          state_d    = S_SEND;
        end
      end
      S_WAIT: begin
        if (i_MOSI_ready) begin
          frame_done_d = 1'b1;
          frame_end_c  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        mosidv_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
    cmd_ready_d = ((wptr_d - rptr_d) != PW'(FIFO_DEPTH));
    busy_d      = (state_d != S_IDLE) || (wptr_d != rptr_d);
  end

  always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
    if (!i_FPGA_rst) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      frame_q      <= '0;
      byte_idx_q   <= '0;
      mosi_q       <= '0;
      mosidv_q     <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      frame_q      <= frame_d;
      byte_idx_q   <= byte_idx_d;
      mosi_q       <= mosi_d;
      mosidv_q     <= mosidv_d;
      frame_done_q <= frame_done_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign o_MOSI_count = 5'(FRAME_BYTES);
  assign o_MOSI       = mosi_q;
  assign o_MOSIdv     = mosidv_q;
  assign o_frame_done = frame_done_q;
  assign o_cmd_ready  = cmd_ready_q;
  assign o_busy       = busy_q;

`ifdef LTC2668_READBACK_EN
  logic [23:0]   sr_q, sr_d, rdbk_q, rdbk_d;
  logic [RW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rdbk_valid_q, rdbk_valid_d;

  // echo only published when a complete frame was shifted in
  always_comb begin
    sr_d         = sr_q;
    rx_cnt_d     = rx_cnt_q;
    rdbk_d       = rdbk_q;
    rdbk_valid_d = 1'b0;
    if (i_MISOdv) begin
      sr_d = {sr_q[15:0], i_MISO};
      if (rx_cnt_q != '1) rx_cnt_d = rx_cnt_q + RW'(1);
    end
    if (frame_start_c) rx_cnt_d = '0;
    if (frame_end_c && (rx_cnt_q == RW'(FRAME_BYTES))) begin
      rdbk_d       = sr_q;
      rdbk_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
    if (!i_FPGA_rst) begin
      sr_q         <= '0;
      rx_cnt_q     <= '0;
      rdbk_q       <= '0;
      rdbk_valid_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      rx_cnt_q     <= rx_cnt_d;
      rdbk_q       <= rdbk_d;
      rdbk_valid_q <= rdbk_valid_d;
    end
  end

  assign o_rdbk       = rdbk_q;
  assign o_rdbk_valid = rdbk_valid_q;
`else
  logic unused_rx;
  assign unused_rx    = ^{i_MISO, i_MISOdv, frame_start_c, frame_end_c};
  assign o_rdbk       = '0;
  assign o_rdbk_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ltc2668_cmd_sequencer.sv
// Scoreboard bench for ltc2668_cmd_sequencer with a simple SPIMasterCS responder model.
module tb_ltc2668_cmd_sequencer;

`ifdef LTC2668_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic [3:0]  i_cmd, i_addr;
  logic [15:0] i_data;
  logic        i_cmd_valid, o_cmd_ready;
  logic [4:0]  o_MOSI_count;
  logic [7:0]  o_MOSI, i_MISO;
  logic        o_MOSIdv, i_MOSI_ready, i_MISOdv;
  logic [23:0] o_rdbk;
  logic        o_rdbk_valid, o_frame_done, o_busy;

  ltc2668_cmd_sequencer dut (
    .i_FPGA_clk(clk), .i_FPGA_rst(rst_n),
    .i_cmd(i_cmd), .i_addr(i_addr), .i_data(i_data),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .o_MOSI_count(o_MOSI_count), .o_MOSI(o_MOSI), .o_MOSIdv(o_MOSIdv),
    .i_MOSI_ready(i_MOSI_ready), .i_MISO(i_MISO), .i_MISOdv(i_MISOdv),
    .o_rdbk(o_rdbk), .o_rdbk_valid(o_rdbk_valid),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_bytes [$];
  logic [24:0] exp_frames [$];
  logic [23:0] model_rdbk = 24'h0;
  logic [23:0] echo_word  = 24'h123456;
  logic        short_mode = 1'b0;
  logic        stall      = 1'b0;
  logic        slave_rdy;
  int          bytes_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // SPIMasterCS model: ready drops while a byte is offered, echoes one SDO byte per MOSI byte
  assign i_MOSI_ready = slave_rdy & ~stall & ~o_MOSIdv;

  initial begin
    int busy, s_idx, s_cur;
    logic s_last;
    logic [23:0] tmp;
    slave_rdy = 1'b1; busy = 0; s_idx = 0; s_cur = 0; s_last = 1'b0;
    i_MISO = 8'h00; i_MISOdv = 1'b0;
    forever begin
      @(negedge clk);
      i_MISOdv = 1'b0;
      if (!rst_n) begin
        slave_rdy = 1'b1; busy = 0; s_idx = 0; s_last = 1'b0;
      end else if (o_MOSIdv) begin
        s_cur  = s_idx;
        s_last = (s_idx == 2);
        s_idx  = s_last ? 0 : s_idx + 1;
        busy   = s_last ? 5 : 3;
        slave_rdy = 1'b0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 1) begin
          tmp      = echo_word >> (16 - 8 * s_cur);
          i_MISO   = tmp[7:0];
          i_MISOdv = !(short_mode && s_last);
        end
        if (busy == 0) slave_rdy = 1'b1;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a byte or a frame end
  initial begin
    int cyc, done_cyc, mon_idx;
    logic prev_dv, have_done;
    logic [7:0] eb;
    logic [24:0] ef;
    cyc = 0; done_cyc = 0; mon_idx = 0; prev_dv = 1'b0; have_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_dv = 1'b0; mon_idx = 0; have_done = 1'b0;
      end else begin
        if (o_MOSIdv) begin
          check("mosidv_width", 32'(prev_dv), 32'd0);
          if (exp_bytes.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte actual=%h required=none", o_MOSI);
          end else begin
            eb = exp_bytes.pop_front();
            check("mosi_byte", 32'(o_MOSI), 32'(eb));
          end
          if (mon_idx == 0 && have_done) begin
            checks++;
            if (cyc - done_cyc < 2) begin
              errors++;
              $display("FAIL frame_gap actual=%0d required>=2", cyc - done_cyc);
            end
          end
          mon_idx = (mon_idx == 2) ? 0 : mon_idx + 1;
          bytes_seen++;
        end
        if (o_frame_done) begin
          check("done_on_boundary", 32'(mon_idx), 32'd0);
          if (exp_frames.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame_done actual=1 required=0");
          end else begin
            ef = exp_frames.pop_front();
            check("rdbk_valid", 32'(o_rdbk_valid), 32'(ef[24]));
            check("rdbk_value", 32'(o_rdbk), 32'(ef[23:0]));
          end
          done_cyc  = cyc;
          have_done = 1'b1;
        end else if (o_rdbk_valid) begin
          checks++; errors++;
          $display("FAIL rdbk_valid_stray actual=1 required=0");
        end
        prev_dv = o_MOSIdv;
      end
    end
  end

  task automatic push(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d,
                      input int nb, input bit fr);
    logic [23:0] w;
    w = {c, a, d};
    i_cmd = c; i_addr = a; i_data = d; i_cmd_valid = 1'b1;
    for (int k = 0; k < nb; k++) begin
      exp_bytes.push_back(w[23:16]);
      w = w << 8;
    end
    if (fr) begin
      if (!RB_EN) exp_frames.push_back(25'h0);
      else if (short_mode) exp_frames.push_back({1'b0, model_rdbk});
      else begin
        model_rdbk = echo_word;
        exp_frames.push_back({1'b1, echo_word});
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_frames.size() != 0 || o_busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d bytes pending required=0", name, exp_bytes.size());
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ready"}, 32'(o_cmd_ready), 32'd1);
    check({name, "_mosi"}, 32'(o_MOSI), 32'd0);
    check({name, "_mosidv"}, 32'(o_MOSIdv), 32'd0);
    check({name, "_rdbk"}, 32'(o_rdbk), 32'd0);
    check({name, "_rdbk_valid"}, 32'(o_rdbk_valid), 32'd0);
    check({name, "_done"}, 32'(o_frame_done), 32'd0);
    check({name, "_busy"}, 32'(o_busy), 32'd0);
    check({name, "_count"}, 32'(o_MOSI_count), 32'd3);
  endtask

  initial begin
    int b0, n;
    rst_n = 1'b0; i_cmd = '0; i_addr = '0; i_data = '0; i_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single write with full echo, plus first-byte latency
    push(4'h3, 4'h5, 16'hABCD, 3, 1'b1);
    i_cmd_valid = 1'b0;
    check("lat_n0", 32'(o_MOSIdv), 32'd0);
    @(negedge clk);
    check("lat_n1", 32'(o_MOSIdv), 32'd0);
    @(negedge clk);
    check("lat_n2", 32'(o_MOSIdv), 32'd1);
    wait_idle("single");
    repeat (2) @(negedge clk);
    check("single_busy_low", 32'(o_busy), 32'd0);

    // short echo: rdbk must keep the previous frame's value
    short_mode = 1'b1; echo_word = 24'h654321;
    push(4'h1, 4'h2, 16'h0F0F, 3, 1'b1);
    i_cmd_valid = 1'b0;
    wait_idle("short");
    short_mode = 1'b0; echo_word = 24'hC0FFEE;
    check("short_rdbk_hold", 32'(o_rdbk), RB_EN ? 32'h123456 : 32'h0);

    // FIFO full: one frame stalled in SEND, then four fill the FIFO and a fifth is dropped
    stall = 1'b1;
    push(4'h2, 4'h0, 16'h1111, 3, 1'b1);
    i_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    push(4'h2, 4'h1, 16'h2222, 3, 1'b1);
    push(4'h2, 4'h2, 16'h3333, 3, 1'b1);
    push(4'h2, 4'h3, 16'h4444, 3, 1'b1);
    push(4'h2, 4'h4, 16'h5555, 3, 1'b1);
    i_cmd_valid = 1'b0;
    check("full_ready_low", 32'(o_cmd_ready), 32'd0);
    push(4'h2, 4'h5, 16'h6666, 0, 1'b0);
    i_cmd_valid = 1'b0;
    check("full_still_low", 32'(o_cmd_ready), 32'd0);
    stall = 1'b0;
    wait_idle("full");
    check("full_ready_back", 32'(o_cmd_ready), 32'd1);

    // reset after the second byte with two commands still queued
    echo_word = 24'h123456;
    b0 = bytes_seen;
    push(4'h3, 4'h7, 16'hBEEF, 2, 1'b0);
    push(4'h3, 4'h8, 16'hCAFE, 0, 1'b0);
    push(4'h3, 4'h9, 16'hF00D, 0, 1'b0);
    i_cmd_valid = 1'b0;
    n = 0;
    while (bytes_seen < b0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_two_bytes_seen", 32'(bytes_seen - b0), 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    model_rdbk = 24'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_reset_vals("post_rst");
    check("post_rst_no_bytes", 32'(bytes_seen - b0), 32'd2);

    // back-to-back commands in consecutive cycles
    push(4'h3, 4'hA, 16'h0102, 3, 1'b1);
    push(4'h3, 4'hB, 16'h0304, 3, 1'b1);
    i_cmd_valid = 1'b0;
    wait_idle("b2b");
    check("b2b_rdbk", 32'(o_rdbk), RB_EN ? 32'h123456 : 32'h0);

    repeat (5) @(negedge clk);
    check("end_bytes_empty", 32'(exp_bytes.size()), 32'd0);
    check("end_frames_empty", 32'(exp_frames.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
